seq_detect_prog: RTL and testbench

Programmable serial bit-pattern detector; the parametrised successor to the team's fixed-pattern Moore detectors. It watches a 1-bit serial stream qualified by a valid strobe and compares it against a run-time loadable pattern of PAT_W bits. A pattern can be matched in overlapping or non-overlapping mode, and each match produces a registered one-cycle pulse. It sits between the serial deserialiser front end and the frame/sync logic.

---
 rtl/seq_detect_prog.sv | 126 ++++++++++++
 tb/tb_seq_detect_prog.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// seq_detect_prog
//   Programmable serial bit-pattern detector. Accepts one bit per cycle when
//   x_vld is high and compares the most recent PAT_W accepted bits against a
//   run-time loadable pattern. Each hit gives a registered one-cycle match
//   pulse. Detection is overlapping (overlap=1) or non-overlapping (overlap=0).
//
//   Optional feature macro: SEQDET_COUNT_EN adds a saturating match counter
//   and the match_cnt output port.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset (wins over everything)
//   x          in   serial data bit
//   x_vld      in   qualifies x
//   overlap    in   1 = overlapping, 0 = non-overlapping detection
//   pat_in     in   PAT_W  new pattern, MSB is the first bit received
//   pat_load   in   load pat_in; discards any bit offered in the same cycle
//   match      out  one-cycle pulse per hit
//   fill       out  valid history bits, saturating at PAT_W
//   match_cnt  out  CNT_W  saturating hit count (SEQDET_COUNT_EN only)

module seq_detect_prog #(
  parameter int              PAT_W   = 4,
  parameter int              CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = 4'b1001
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         x,
  input  logic                         x_vld,
  input  logic                         overlap,
  input  logic [PAT_W-1:0]             pat_in,
  input  logic                         pat_load,
  output logic                         match,
`ifdef SEQDET_COUNT_EN
  output logic [CNT_W-1:0]             match_cnt,
`endif
  output logic [$clog2(PAT_W+1)-1:0]   fill
);

  localparam int FW = $clog2(PAT_W+1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);
  localparam logic [FW-1:0] FILL_ARM  = FW'(PAT_W-1);

  if (PAT_W < 2 || PAT_W > 16 || CNT_W < 1) begin : g_bad_param
    $error("seq_detect_prog: PAT_W must be 2..16 and CNT_W >= 1");
  end

  // Only the newest PAT_W-1 bits are kept: the oldest bit of a PAT_W window
  // is shifted out on the very bit that completes the comparison, so it never
  // takes part in a hit.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             match_q, match_d;

  logic [PAT_W-1:0] cand;
  logic             accept;
  logic             hit;

  always_comb begin
    accept  = x_vld && !pat_load;
    cand    = {hist_q, x};
    hit     = accept && (fill_q >= FILL_ARM) && (cand == pat_q);

    hist_d  = hist_q;
    pat_d   = pat_q;
    fill_d  = fill_q;
    match_d = hit;

    if (pat_load) begin
      pat_d  = pat_in;
      fill_d = '0;
    end else if (x_vld) begin
      hist_d = cand[PAT_W-2:0];
      if (hit) begin
        // Overlap keeps the window armed so the hit's suffix can seed the
        // next match; non-overlap demands PAT_W fresh bits.
        fill_d = overlap ? FILL_FULL : '0;
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q  <= '0;
      pat_q   <= RST_PAT;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;
  assign fill  = fill_q;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts alongside the match pulse; holds at all-ones. Pattern loads
  // leave it alone, only reset clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
module tb_seq_detect_prog;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
  localparam logic [PAT_W-1:0] RST_PAT = 4'b1001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       x;
  logic       x_vld;
  logic       overlap;
  logic [3:0] pat_in;
  logic       pat_load;
  logic       match;
  logic [2:0] fill;
`ifdef SEQDET_COUNT_EN
  logic [1:0] match_cnt;
`endif

  seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(CNT_W), .RST_PAT(RST_PAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .x_vld    (x_vld),
    .overlap  (overlap),
    .pat_in   (pat_in),
    .pat_load (pat_load),
    .match    (match),
`ifdef SEQDET_COUNT_EN
    .match_cnt(match_cnt),
`endif
    .fill     (fill)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int pulses = 0;

  // Reference model: the list of bits accepted since the window was last
  // cleared (reset, load, or a non-overlapping hit), capped to PAT_W entries.
  bit         win[$];
  logic [3:0] m_pat;
  logic       m_match;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic xi, vi, oi, input logic [3:0] pi, input logic li, ri);
    bit hit;
    if (!ri) begin
      win.delete();
      m_pat = RST_PAT; m_cnt = 0; m_match = 1'b0;
    end else if (li) begin
      win.delete();
      m_pat = pi; m_match = 1'b0;
    end else if (vi) begin
      win.push_back(xi);
      if (win.size() > PAT_W) void'(win.pop_front());
      hit = (win.size() == PAT_W);
      for (int i = 0; i < PAT_W; i++)
        if (hit && win[i] != m_pat[PAT_W-1-i]) hit = 1'b0;
      m_match = hit;
      if (hit) begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!oi) win.delete();
      end
    end else begin
      m_match = 1'b0;
    end
  endtask

  task automatic step(input logic xi, vi, oi, input logic [3:0] pi, input logic li, ri);
    x = xi; x_vld = vi; overlap = oi; pat_in = pi; pat_load = li; rst_n = ri;
    @(posedge clk);
    model_step(xi, vi, oi, pi, li, ri);
    #1;
    if (match === 1'b1) pulses++;
    chk("match", 32'(match), 32'(m_match));
    chk("fill", 32'(fill), 32'(win.size()));
`ifdef SEQDET_COUNT_EN
    chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic bit_in(input logic b, input logic ovl);
    step(b, 1'b1, ovl, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic idle(input logic ovl);
    step(1'b0, 1'b0, ovl, 4'h0, 1'b0, 1'b1);
  endtask

  logic [6:0] s7;
  logic [3:0] s4;

  initial begin
    x = 0; x_vld = 0; overlap = 0; pat_in = 0; pat_load = 0; rst_n = 0;

    // Reset state
    do_reset();
    do_reset();
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);

    // Overlapping 1001001 -> two hits
    s7 = 7'b1001001;
    pulses = 0;
    for (int i = 6; i >= 0; i--) bit_in(s7[i], 1'b1);
    idle(1'b1);
    chk("ovl_pulses", 32'(pulses), 32'd2);
`ifdef SEQDET_COUNT_EN
    chk("ovl_cnt", 32'(match_cnt), 32'd2);
`endif

    // Non-overlapping 1001001 -> one hit, fill ends at 3
    do_reset();
    pulses = 0;
    for (int i = 6; i >= 0; i--) begin
      bit_in(s7[i], 1'b0);
      if (i == 3) chk("novl_fill_after_hit", 32'(fill), 32'd0);
    end
    idle(1'b0);
    chk("novl_pulses", 32'(pulses), 32'd1);
    chk("novl_fill_end", 32'(fill), 32'd3);

    // Load 1011 with a concurrent valid bit; then gapped stream
    step(1'b1, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b1);
    chk("load_fill", 32'(fill), 32'd0);
    s4 = 4'b1011;
    pulses = 0;
    for (int i = 3; i >= 0; i--) begin
      bit_in(s4[i], 1'b1);
      if (i == 0) chk("gap_match_final", 32'(match), 32'd1);
      if (i != 0) begin
        idle(1'b1);
        idle(1'b1);
      end
    end
    idle(1'b1);
    chk("gap_pulses", 32'(pulses), 32'd1);

    // Reset mid-pattern discards history
    do_reset();
    bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b0, 1'b1);
    do_reset();
    pulses = 0;
    bit_in(1'b1, 1'b1);
    chk("midrst_fill", 32'(fill), 32'd1);
    chk("midrst_pulses", 32'(pulses), 32'd0);
`ifdef SEQDET_COUNT_EN
    chk("midrst_cnt", 32'(match_cnt), 32'd0);
`endif

    // All-ones pattern, overlapping -> hits on bits 4..8, counter saturates
    step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      bit_in(1'b1, 1'b1);
      chk("ones_match", 32'(match), (i >= 4) ? 32'd1 : 32'd0);
    end
    chk("ones_pulses", 32'(pulses), 32'd5);
`ifdef SEQDET_COUNT_EN
    chk("ones_cnt_sat", 32'(match_cnt), 32'd3);
`endif

    // Randomised traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic       rx, rv, ro, rl, rr;
      logic [3:0] rp;
      rx = 1'($urandom);
      rv = ($urandom_range(0, 9) < 7);
      ro = 1'($urandom);
      rl = ($urandom_range(0, 24) == 0);
      rr = !($urandom_range(0, 59) == 0);
      rp = 4'($urandom);
      step(rx, rv, ro, rp, rl, rr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
